// File: rtl/mem_bist_if.sv
// Memory-side bus of the BIST initiator: strobes, address and data.
// master = BIST controller, slave = memory under test.
interface mem_bist_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 4
);
  logic [WIDTH-1:0]   in_data;
  logic [ADDRESS-1:0] address;
  logic               wr_en;
  logic               rd_en;
  logic [WIDTH-1:0]   out_data;
  logic               valid_out;

  modport master (
    output in_data, address, wr_en, rd_en,
    input  out_data, valid_out
  );

  modport slave (
    input  in_data, address, wr_en, rd_en,
    output out_data, valid_out
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST initiator: write seed pattern, read back, compare, report.
// Define MEM_BIST_INV_PASS_EN to add a second pass with inverted data.
module mem_bist_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int ADDRESS = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   seed,
  mem_bist_if.master         mem,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               timeout_seen,
  output logic [ADDRESS-1:0] fail_addr,
  output logic [WIDTH-1:0]   fail_data,
  output logic [ADDRESS:0]   fail_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDRESS-1:0] LAST = ADDRESS'(DEPTH - 1);
  localparam logic [ADDRESS:0]   CMAX = (ADDRESS + 1)'(DEPTH);
  localparam logic [TW-1:0]      TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ_REQ, READ_WAIT, DONE
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   seed_q, seed_d;
  logic [ADDRESS-1:0] addr, addr_d;
  logic [TW-1:0]      timer, timer_d;
  logic [WIDTH-1:0]   in_data_q, in_data_d;
  logic [ADDRESS-1:0] address_q, address_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_d, done_d, fail_d, to_d;
  logic [ADDRESS-1:0] fa_d;
  logic [WIDTH-1:0]   fd_d;
  logic [ADDRESS:0]   fc_d;
  logic               hit, miss;
  logic [WIDTH-1:0]   rdata;

`ifdef MEM_BIST_INV_PASS_EN
  logic pass, pass_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pass <= 1'b0;
    else      pass <= pass_d;
  end
`else
  logic pass;
  assign pass = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] pattern(
    input logic [WIDTH-1:0]   s,
    input logic [ADDRESS-1:0] a,
    input logic               p
  );
    logic [WIDTH-1:0] w;
    w = s ^ WIDTH'(a);
    return p ? ~w : w;
  endfunction

  always_comb begin
    state_d = state;
    seed_d  = seed_q;
    addr_d  = addr;
    timer_d = timer;
    done_d  = done;
    fail_d  = fail;
    to_d    = timeout_seen;
    fa_d    = fail_addr;
    fd_d    = fail_data;
    fc_d    = fail_count;
    hit     = 1'b0;
    miss    = 1'b0;
    rdata   = mem.out_data;
`ifdef MEM_BIST_INV_PASS_EN
    pass_d  = pass;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          seed_d  = seed;
          addr_d  = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          fa_d    = '0;
          fd_d    = '0;
          fc_d    = '0;
`ifdef MEM_BIST_INV_PASS_EN
          pass_d  = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (addr == LAST) begin
          state_d = READ_REQ;
          addr_d  = '0;
        end else begin
          addr_d = addr + 1'b1;
        end
      end
      READ_REQ: begin
        timer_d = '0;
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        timer_d = timer + 1'b1;
        // a response landing on the expiry cycle still counts as a read
        if (mem.valid_out) begin
          hit  = 1'b1;
          miss = mem.out_data != pattern(seed_q, addr, pass);
        end else if (timer == TLAST) begin
          hit   = 1'b1;
          miss  = 1'b1;
          rdata = '0;
          to_d  = 1'b1;
        end
        if (miss) begin
          fail_d = 1'b1;
          if (fail_count == '0) begin
            fa_d = addr;
            fd_d = rdata;
          end
          if (fail_count != CMAX) fc_d = fail_count + 1'b1;
        end
        if (hit) begin
          if (addr != LAST) begin
            addr_d  = addr + 1'b1;
            state_d = READ_REQ;
          end else begin
`ifdef MEM_BIST_INV_PASS_EN
            if (!pass) begin
              pass_d  = 1'b1;
              addr_d  = '0;
              state_d = WRITE;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state
    wr_en_d   = state_d == WRITE;
    rd_en_d   = state_d == READ_REQ;
    address_d = addr_d;
    busy_d    = state_d inside {WRITE, READ_REQ, READ_WAIT};
    if (state_d == DONE) done_d = 1'b1;
`ifdef MEM_BIST_INV_PASS_EN
    in_data_d = pattern(seed_d, addr_d, pass_d);
`else
    in_data_d = pattern(seed_d, addr_d, 1'b0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      seed_q       <= '0;
      addr         <= '0;
      timer        <= '0;
      in_data_q    <= '0;
      address_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      timeout_seen <= 1'b0;
      fail_addr    <= '0;
      fail_data    <= '0;
      fail_count   <= '0;
    end else begin
      state        <= state_d;
      seed_q       <= seed_d;
      addr         <= addr_d;
      timer        <= timer_d;
      in_data_q    <= in_data_d;
      address_q    <= address_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      busy         <= busy_d;
      done         <= done_d;
      fail         <= fail_d;
      timeout_seen <= to_d;
      fail_addr    <= fa_d;
      fail_data    <= fd_d;
      fail_count   <= fc_d;
    end
  end

  assign mem.in_data = in_data_q;
  assign mem.address = address_q;
  assign mem.wr_en   = wr_en_q;
  assign mem.rd_en   = rd_en_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memory with latency/fault/drop
// injection and a pass-level reference model of the expected report.
module tb_mem_bist_ctrl;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int ADDRESS = 4;
  localparam int TIMEOUT = 8;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   seed = '0;
  logic               busy, done, fail, timeout_seen;
  logic [ADDRESS-1:0] fail_addr;
  logic [WIDTH-1:0]   fail_data;
  logic [ADDRESS:0]   fail_count;

  mem_bist_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) mem ();

  mem_bist_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS(ADDRESS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .mem(mem),
    .busy(busy), .done(done), .fail(fail),
    .timeout_seen(timeout_seen), .fail_addr(fail_addr),
    .fail_data(fail_data), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]   marr [DEPTH];
  logic [WIDTH-1:0]   flip [DEPTH];
  bit                 drop [DEPTH];
  int                 lat = 1;
  bit                 stray = 1'b0;
  int                 cnt = 0;
  logic [ADDRESS-1:0] paddr = '0;

  // memory with read latency lat; drop suppresses the response entirely
  always @(posedge clk) begin
    mem.valid_out <= 1'b0;
    if (mem.wr_en) begin
      marr[mem.address] <= mem.in_data;
      if (stray) begin
        mem.valid_out <= 1'b1;
        mem.out_data  <= $urandom;
      end
    end
    if (mem.rd_en) begin
      if (!drop[mem.address]) begin
        if (lat == 1) begin
          mem.valid_out <= 1'b1;
          mem.out_data  <= marr[mem.address] ^ flip[mem.address];
        end else begin
          cnt   <= lat - 1;
          paddr <= mem.address;
        end
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem.valid_out <= 1'b1;
        mem.out_data  <= marr[paddr] ^ flip[paddr];
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      flip[a] = '0;
      drop[a] = 1'b0;
    end
  endtask

  task automatic run(input string name, input logic [WIDTH-1:0] s,
                     input int restart_at);
    int               ecyc, efc, cyc, wrc, firstrd, both, nbad;
    logic [ADDRESS-1:0] efa;
    logic [WIDTH-1:0] efd, e, d, last;
    bit               efail, eto, got, badrd;
    ecyc = 1; efc = 0; efa = '0; efd = '0; efail = 0; eto = 0;
    for (int p = 0; p < PASSES; p++) begin
      ecyc += DEPTH;
      for (int a = 0; a < DEPTH; a++) begin
        e = s ^ 32'(a);
        if (p == 1) e = ~e;
        ecyc += 1;
        if (drop[a]) begin
          ecyc += TIMEOUT; d = '0; badrd = 1; eto = 1;
        end else begin
          ecyc += lat; d = e ^ flip[a]; badrd = flip[a] != '0;
        end
        if (badrd) begin
          if (efc == 0) begin
            efa = ADDRESS'(a); efd = d;
          end
          if (efc < DEPTH) efc++;
          efail = 1;
        end
      end
    end
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed = $urandom;
    chk({name, ":done_clear"}, done, 0);
    cyc = 0; wrc = 0; firstrd = 0; both = 0; got = 0;
    while (cyc < ecyc + 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (mem.wr_en) wrc++;
      if (mem.rd_en && firstrd == 0) firstrd = cyc;
      if (mem.wr_en && mem.rd_en) both++;
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    chk({name, ":done_cycle"}, got ? cyc : 0, ecyc);
    chk({name, ":busy"}, busy, 0);
    chk({name, ":fail"}, fail, efail);
    chk({name, ":timeout_seen"}, timeout_seen, eto);
    chk({name, ":fail_count"}, fail_count, efc);
    chk({name, ":fail_addr"}, fail_addr, efa);
    chk({name, ":fail_data"}, fail_data, efd);
    chk({name, ":wr_cycles"}, wrc, DEPTH * PASSES);
    chk({name, ":first_rd"}, firstrd, DEPTH + 1);
    chk({name, ":overlap"}, both, 0);
    nbad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      last = s ^ 32'(a);
      if (PASSES == 2) last = ~last;
      if (marr[a] !== last) nbad++;
    end
    chk({name, ":contents"}, nbad, 0);
    @(negedge clk);
    chk({name, ":done_held"}, done, 1);
  endtask

  initial begin
    clear_faults();
    for (int a = 0; a < DEPTH; a++) marr[a] = '0;
    repeat (3) @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:fail", fail, 0);
    chk("rst:timeout", timeout_seen, 0);
    chk("rst:fail_addr", fail_addr, 0);
    chk("rst:fail_data", fail_data, 0);
    chk("rst:fail_count", fail_count, 0);
    chk("rst:strobes", {mem.wr_en, mem.rd_en}, 0);
    chk("rst:address", mem.address, 0);
    chk("rst:in_data", mem.in_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run("ideal", 32'hA5A5_0000, 0);

    flip[5] = 32'h1;
    run("flip5", 32'hA5A5_0000, 0);
    clear_faults();

    for (int a = 0; a < DEPTH; a++) drop[a] = 1'b1;
    run("novalid", 32'hA5A5_0000, 0);
    clear_faults();

    run("restart", 32'h1234_5678, 10);

    // abort mid-write, then a full test must still work
    @(negedge clk);
    seed = 32'hDEAD_BEEF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort:wr_en", mem.wr_en, 0);
    chk("abort:rd_en", mem.rd_en, 0);
    chk("abort:busy", busy, 0);
    chk("abort:status", {done, fail, timeout_seen, fail_count}, 0);
    repeat (3) @(negedge clk);
    chk("abort:quiet", {mem.wr_en, mem.rd_en, busy}, 0);
    rst = 1'b1;
    run("after_abort", 32'h0F0F_0F0F, 0);

    lat = TIMEOUT;
    run("lat_edge", 32'h5555_AAAA, 0);
    lat = 1;

    run("seed0", 32'h0, 0);
`ifdef MEM_BIST_INV_PASS_EN
    chk("inv:word0", marr[0], 32'hFFFF_FFFF);
    chk("inv:word15", marr[15], 32'hFFFF_FFF0);
`endif

    for (int t = 0; t < 6; t++) begin
      lat = $urandom_range(1, TIMEOUT);
      stray = $urandom_range(0, 1);
      for (int a = 0; a < DEPTH; a++) begin
        flip[a] = ($urandom_range(0, 7) == 0) ?
                  (32'h1 << $urandom_range(0, 31)) : '0;
        drop[a] = ($urandom_range(0, 15) == 0);
      end
      run($sformatf("rand%0d", t), $urandom, 0);
    end
    clear_faults();
    stray = 1'b0;
    lat = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Memory built-in self-test initiator for the single-port memory block: it drives `in_data`/`address`/`wr_en`/`rd_en` and consumes `out_data`/`valid_out`. On `start` it writes a seed-derived pattern to every address, reads each word back, and compares it against the expected value. It reports pass/fail, the first failing address and data, and a mismatch count. It sits between system control and the memory, replacing the testbench driver in silicon self-test builds.

## Interface
- `WIDTH`, 32, data width
- `DEPTH`, 16, number of words tested (addresses 0..DEPTH-1)
- `ADDRESS`, 4, address width
- `TIMEOUT`, 8, cycles to wait for `valid_out` before declaring a read lost
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: begin test; sampled only in IDLE
- `seed` in WIDTH: pattern seed, sampled with `start`
- `in_data` out WIDTH: write data to memory
- `address` out ADDRESS: memory address
- `wr_en` out 1: memory write strobe
- `rd_en` out 1: memory read strobe
- `out_data` in WIDTH: memory read data
- `valid_out` in 1: `out_data` valid
- `busy` out 1: test in progress
- `done` out 1: test finished; held until next accepted `start`
- `fail` out 1: at least one mismatch or timeout; held with `done`
- `timeout_seen` out 1: at least one read timed out
- `fail_addr` out ADDRESS: address of first failure
- `fail_data` out WIDTH: data read at first failure (0 if it timed out)
- `fail_count` out ADDRESS+1: number of failing reads, max DEPTH

## Operation
- Expected word: `exp(a,p) = (seed ^ zero-extend(a))`, bitwise inverted when pass `p`=1.
- FSM states are IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- **IDLE**
  - All memory strobes are low.
  - On `start`=1, latch `seed`, set addr=0 and pass=0, and clear `done`, `fail`, `timeout_seen`, `fail_count`, `fail_addr` and `fail_data`.
  - Go to WRITE.
- **WRITE**
  - Drive `wr_en`=1, `address`=addr and `in_data`=exp(addr,pass) every cycle.
  - After addr=DEPTH-1, go to READ_REQ with addr=0.
- **READ_REQ**
  - Drive `rd_en`=1 and `address`=addr for exactly one cycle.
  - Clear the timer and go to READ_WAIT.
- **READ_WAIT**
  - Both strobes are low; the timer increments.
  - On `valid_out`=1, compare `out_data` with exp(addr,pass).
  - If the timer reaches TIMEOUT without `valid_out`, record a failure with data 0 and set `timeout_seen`.
  - On any failure: increment `fail_count` and set `fail`. If it is the first failure, capture `fail_addr`=addr and `fail_data`.
  - Then: if addr<DEPTH-1, addr++ and go to READ_REQ. Otherwise go to the next pass (if enabled) or to DONE.
- **DONE**
  - Set `done`=1 and go to IDLE. `busy` drops in the same cycle.
- Protocol rules:
  - `start` while `busy` is ignored.
  - `valid_out` outside READ_WAIT is ignored.
  - A `valid_out` on the same cycle the timer expires counts as a valid read, not a timeout.
  - `wr_en` and `rd_en` are never high together.
  - Only one read is outstanding at a time.
- Address wraps are never generated; addr stops at DEPTH-1.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the FSM is in IDLE.
- Reset asserted mid-test aborts the test immediately. Strobes drop asynchronously and no further memory traffic occurs.
- `start` sampled at edge 0 gives:
  - `wr_en` high for cycles 1..DEPTH;
  - the first `rd_en` at cycle DEPTH+1.
- Read cost per address is 1+L cycles for a memory with read latency L (`valid_out` L cycles after `rd_en`), or 1+TIMEOUT cycles on timeout.
- With L=1 and DEPTH=16, `done` rises at cycle 3·DEPTH+1 = 49 per pass.

## Configuration
- `MEM_BIST_INV_PASS_EN` defined:
  - After pass 0 reads complete, set pass=1, addr=0, and repeat WRITE and READ with inverted data. Only then go to DONE.
  - With L=1, `done` rises at cycle 6·DEPTH+1.
  - `fail_count` saturates at DEPTH.
- Undefined: single pass only; the pass bit is tied to 0.

## Test plan
- Ideal L=1 memory, seed=0xA5A5_0000 → writes 0xA5A5_0000..0xA5A5_000F to addresses 0..15; `done`=1 at cycle 49, `fail`=0, `fail_count`=0.
- Memory model flips bit 0 on read of address 5, seed=0xA5A5_0000 → `fail`=1, `fail_addr`=5, `fail_data`=0xA5A5_0004, `fail_count`=1, `timeout_seen`=0.
- Memory never asserts `valid_out` → each read takes 9 cycles; `fail_count`=16, `timeout_seen`=1, `fail_addr`=0, `fail_data`=0.
- `start` pulsed again at cycle 10 of a running test → ignored; the test completes normally and `done` rises at cycle 49.
- `rst` driven low at cycle 7 of WRITE → all strobes and status go to 0 immediately. A fresh `start` after release runs a full test.
- With `MEM_BIST_INV_PASS_EN`, seed=0 → pass 1 writes 0xFFFF_FFFF at address 0 and 0xFFFF_FFF0 at address 15; `done` rises at cycle 97, `fail`=0.
